// File: rtl/pkt_dvdr_rx_parser_if.sv
// Byte-stream receive bus and parsed payload/status bundle for the packet parser.
// The slave side is the parser; the master side feeds bytes and observes results.
interface pkt_dvdr_rx_parser_if;
    logic        rx_en;
    logic [7:0]  rx_data;
    logic        pld_valid;
    logic [7:0]  pld_data;
    logic        pld_first;
    logic        pld_last;
    logic        pkt_done;
    logic        pkt_err;
    logic [4:0]  err_flags;
    logic [7:0]  pkt_len;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    modport slave (
        input  rx_en, rx_data,
        output pld_valid, pld_data, pld_first, pld_last,
        output pkt_done, pkt_err, err_flags, pkt_len, good_cnt, bad_cnt
    );

    modport master (
        output rx_en, rx_data,
        input  pld_valid, pld_data, pld_first, pld_last,
        input  pkt_done, pkt_err, err_flags, pkt_len, good_cnt, bad_cnt
    );
endinterface

// File: rtl/pkt_dvdr_rx_parser.sv
// Parses sop|len|data|pad|parity|eop byte packets, streams the payload one cycle
// later and reports a per-packet status pulse plus good/bad packet counters.
module pkt_dvdr_rx_parser #(
    parameter logic [7:0] SOP_BYTE = 8'hA5,
    parameter logic [7:0] EOP_BYTE = 8'h5A,
    parameter int         MAX_LEN  = 64,
    parameter int         GAP_MAX  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pkt_dvdr_rx_parser_if.slave  rx_if
);
    localparam int            GW       = $clog2(GAP_MAX + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_PAD, S_PARITY, S_EOP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    par_q, par_d;
    logic [1:0]    pad_q, pad_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [4:0]    err_q, err_d;
    logic          pld_valid_q, pld_valid_d;
    logic [7:0]    pld_data_q, pld_data_d;
    logic          pld_first_q, pld_first_d;
    logic          pld_last_q, pld_last_d;
    logic          done_q, done_d;
    logic          pkt_err_q, pkt_err_d;
    logic [4:0]    flags_q, flags_d;
    logic [7:0]    pkt_len_q, pkt_len_d;
    logic [15:0]   good_q, good_d;
    logic [15:0]   bad_q, bad_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            par_q       <= '0;
            pad_q       <= '0;
            gap_q       <= '0;
            err_q       <= '0;
            pld_valid_q <= 1'b0;
            pld_data_q  <= '0;
            pld_first_q <= 1'b0;
            pld_last_q  <= 1'b0;
            done_q      <= 1'b0;
            pkt_err_q   <= 1'b0;
            flags_q     <= '0;
            pkt_len_q   <= '0;
            good_q      <= '0;
            bad_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            par_q       <= par_d;
            pad_q       <= pad_d;
            gap_q       <= gap_d;
            err_q       <= err_d;
            pld_valid_q <= pld_valid_d;
            pld_data_q  <= pld_data_d;
            pld_first_q <= pld_first_d;
            pld_last_q  <= pld_last_d;
            done_q      <= done_d;
            pkt_err_q   <= pkt_err_d;
            flags_q     <= flags_d;
            pkt_len_q   <= pkt_len_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        par_d       = par_q;
        pad_d       = pad_q;
        gap_d       = gap_q;
        err_d       = err_q;
        pld_valid_d = 1'b0;
        pld_data_d  = '0;
        pld_first_d = 1'b0;
        pld_last_d  = 1'b0;
        done_d      = 1'b0;
        pkt_err_d   = 1'b0;
        flags_d     = '0;
        pkt_len_d   = '0;
        good_d      = good_q;
        bad_d       = bad_q;

        if (rx_if.rx_en) begin
            gap_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (rx_if.rx_data == SOP_BYTE) begin
                        state_d = S_LEN;
                        len_d   = '0;
                        idx_d   = '0;
                        par_d   = '0;
                        err_d   = '0;
                    end
                end
                S_LEN: begin
                    if (rx_if.rx_data == 8'd0 || rx_if.rx_data > 8'(MAX_LEN)) begin
                        done_d    = 1'b1;
                        flags_d   = 5'b00001;
                        pkt_len_d = rx_if.rx_data;
                        state_d   = S_IDLE;
                    end else begin
                        len_d   = rx_if.rx_data;
                        par_d   = rx_if.rx_data;
                        // Pad brings len up to a multiple of 4: (4 - len mod 4) mod 4.
                        pad_d   = 2'(8'd0 - rx_if.rx_data);
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    pld_valid_d = 1'b1;
                    pld_data_d  = rx_if.rx_data;
                    pld_first_d = (idx_q == 8'd0);
                    pld_last_d  = (idx_q == len_q - 8'd1);
                    par_d       = par_q ^ rx_if.rx_data;
                    idx_d       = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) begin
                        state_d = (pad_q == 2'd0) ? S_PARITY : S_PAD;
                    end
                end
                S_PAD: begin
                    par_d = par_q ^ rx_if.rx_data;
                    if (rx_if.rx_data != 8'h00) begin
                        err_d[1] = 1'b1;
                    end
                    pad_d = pad_q - 2'd1;
                    if (pad_q == 2'd1) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (rx_if.rx_data != par_q) begin
                        err_d[2] = 1'b1;
                    end
                    state_d = S_EOP;
                end
                S_EOP: begin
                    done_d    = 1'b1;
                    flags_d   = err_q | {1'b0, (rx_if.rx_data != EOP_BYTE), 3'b000};
                    pkt_len_d = len_q;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            // Idle cycles inside a packet count toward the timeout; IDLE itself never times out.
            if (gap_q == GAP_LAST) begin
                done_d    = 1'b1;
                flags_d   = err_q | 5'b10000;
                pkt_len_d = len_q;
                gap_d     = '0;
                state_d   = S_IDLE;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end

        if (done_d) begin
            pkt_err_d = |flags_d;
            if (|flags_d) begin
                if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
            end else begin
                if (good_q != 16'hFFFF) good_d = good_q + 16'd1;
            end
        end
    end

    assign rx_if.pld_valid = pld_valid_q;
    assign rx_if.pld_data  = pld_data_q;
    assign rx_if.pld_first = pld_first_q;
    assign rx_if.pld_last  = pld_last_q;
    assign rx_if.pkt_done  = done_q;
    assign rx_if.pkt_err   = pkt_err_q;
    assign rx_if.err_flags = flags_q;
    assign rx_if.pkt_len   = pkt_len_q;
    assign rx_if.good_cnt  = good_q;
    assign rx_if.bad_cnt   = bad_q;
endmodule

// File: tb/tb_pkt_dvdr_rx_parser.sv
// Self-checking bench: packets are described at field level, expanded into a
// per-cycle expectation queue, then driven and compared cycle by cycle.
module tb_pkt_dvdr_rx_parser;
    localparam int         MAX_LEN = 64;
    localparam int         GAP_MAX = 16;
    localparam logic [7:0] SOP     = 8'hA5;
    localparam logic [7:0] EOP     = 8'h5A;

    typedef struct {
        logic       en;
        logic [7:0] b;
        logic       v;
        logic [7:0] d;
        logic       f;
        logic       l;
        logic       done;
        logic [4:0] fl;
        logic [7:0] pl;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pkt_dvdr_rx_parser_if bus ();

    pkt_dvdr_rx_parser #(
        .SOP_BYTE (SOP),
        .EOP_BYTE (EOP),
        .MAX_LEN  (MAX_LEN),
        .GAP_MAX  (GAP_MAX)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (bus.slave)
    );

    int         total = 0;
    int         bad   = 0;
    int         mdl_good = 0;
    int         mdl_bad  = 0;
    rec_t       exp_q[$];
    logic [7:0] pay_q[$];
    logic [7:0] padv_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic en, input logic [7:0] b);
        rec_t r;
        r = '{default: '0};
        r.en = en;
        r.b  = b;
        return r;
    endfunction

    task automatic push_gaps(input int maxgap);
        int n;
        n = $urandom_range(maxgap, 0);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b0, 8'($urandom)));
    endtask

    // Field-level packet: expectation derived from len, payload, pad, parity and eop rules.
    task automatic add_pkt(input logic [7:0] len, input bit force_par, input logic [7:0] par_val,
                           input logic [7:0] eop_b, input int maxgap);
        rec_t       r;
        logic [7:0] p;
        logic [7:0] par_b;
        bit         pad_e;
        bit         par_e;
        push_gaps(maxgap); exp_q.push_back(mk(1'b1, SOP));
        push_gaps(maxgap); exp_q.push_back(mk(1'b1, len));
        p = len;
        for (int i = 0; i < int'(len); i++) begin
            push_gaps(maxgap);
            r   = mk(1'b1, pay_q[i]);
            r.v = 1'b1;
            r.d = pay_q[i];
            r.f = (i == 0);
            r.l = (i == int'(len) - 1);
            exp_q.push_back(r);
            p ^= pay_q[i];
        end
        pad_e = 1'b0;
        foreach (padv_q[i]) begin
            push_gaps(maxgap);
            exp_q.push_back(mk(1'b1, padv_q[i]));
            p ^= padv_q[i];
            if (padv_q[i] != 8'h00) pad_e = 1'b1;
        end
        par_b = force_par ? par_val : p;
        par_e = (par_b != p);
        push_gaps(maxgap); exp_q.push_back(mk(1'b1, par_b));
        push_gaps(maxgap);
        r      = mk(1'b1, eop_b);
        r.done = 1'b1;
        r.fl   = {1'b0, (eop_b != EOP), par_e, pad_e, 1'b0};
        r.pl   = len;
        exp_q.push_back(r);
    endtask

    task automatic add_bad_len(input logic [7:0] len, input int maxgap);
        rec_t r;
        push_gaps(maxgap); exp_q.push_back(mk(1'b1, SOP));
        push_gaps(maxgap);
        r      = mk(1'b1, len);
        r.done = 1'b1;
        r.fl   = 5'b00001;
        r.pl   = len;
        exp_q.push_back(r);
    endtask

    task automatic set_pad(input logic [7:0] len);
        int npad;
        npad = (4 - (int'(len) % 4)) % 4;
        padv_q.delete();
        for (int i = 0; i < npad; i++) padv_q.push_back(8'h00);
    endtask

    task automatic run_q();
        rec_t r;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            bus.rx_en   = r.en;
            bus.rx_data = r.b;
            @(posedge clk);
            #1;
            chk("pld_valid", 32'(bus.pld_valid), 32'(r.v));
            if (r.v) begin
                chk("pld_data",  32'(bus.pld_data),  32'(r.d));
                chk("pld_first", 32'(bus.pld_first), 32'(r.f));
                chk("pld_last",  32'(bus.pld_last),  32'(r.l));
            end
            chk("pkt_done",  32'(bus.pkt_done),  32'(r.done));
            chk("err_flags", 32'(bus.err_flags), 32'(r.fl));
            chk("pkt_err",   32'(bus.pkt_err),   32'(|r.fl));
            chk("pkt_len",   32'(bus.pkt_len),   32'(r.pl));
            if (r.done) begin
                if (r.fl != 5'd0) begin
                    if (mdl_bad < 65535) mdl_bad++;
                end else begin
                    if (mdl_good < 65535) mdl_good++;
                end
            end else begin
                chk("good_cnt", 32'(bus.good_cnt), 32'(mdl_good));
                chk("bad_cnt",  32'(bus.bad_cnt),  32'(mdl_bad));
            end
        end
        bus.rx_en = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.rx_en   = 1'b1;
        bus.rx_data = SOP;
        @(posedge clk);
        #1;
        chk("rst_pld_valid", 32'(bus.pld_valid), 32'd0);
        chk("rst_pld_data",  32'(bus.pld_data),  32'd0);
        chk("rst_pkt_done",  32'(bus.pkt_done),  32'd0);
        chk("rst_err_flags", 32'(bus.err_flags), 32'd0);
        chk("rst_pkt_len",   32'(bus.pkt_len),   32'd0);
        chk("rst_good_cnt",  32'(bus.good_cnt),  32'd0);
        chk("rst_bad_cnt",   32'(bus.bad_cnt),   32'd0);
        rst       = 1'b0;
        bus.rx_en = 1'b0;
        mdl_good  = 0;
        mdl_bad   = 0;
    endtask

    initial begin
        rec_t       r;
        logic [7:0] len;
        logic [7:0] eop_b;
        logic [7:0] jb;
        int         sel;
        rst         = 1'b1;
        bus.rx_en   = 1'b0;
        bus.rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Basic 3-byte packet with one pad byte
        pay_q = {8'h11, 8'h22, 8'h33};
        set_pad(8'd3);
        add_pkt(8'd3, 1'b0, 8'h00, EOP, 0);
        run_q();

        // Length multiple of 4: no pad, straight to parity
        pay_q = {8'h01, 8'h02, 8'h03, 8'h04};
        set_pad(8'd4);
        add_pkt(8'd4, 1'b0, 8'h00, EOP, 0);
        run_q();

        // Illegal lengths: zero and MAX_LEN+1
        add_bad_len(8'd0, 0);
        add_bad_len(8'(MAX_LEN + 1), 0);
        run_q();

        // Wrong parity and wrong end marker, payload still delivered
        pay_q = {8'h11, 8'h22, 8'h33};
        set_pad(8'd3);
        add_pkt(8'd3, 1'b1, 8'h07, 8'h00, 0);
        run_q();

        // Timeout after GAP_MAX idle cycles inside a packet
        exp_q.push_back(mk(1'b1, SOP));
        exp_q.push_back(mk(1'b1, 8'h02));
        r   = mk(1'b1, 8'hAA);
        r.v = 1'b1;
        r.d = 8'hAA;
        r.f = 1'b1;
        exp_q.push_back(r);
        for (int i = 0; i < GAP_MAX; i++) begin
            r = mk(1'b0, 8'h00);
            if (i == GAP_MAX - 1) begin
                r.done = 1'b1;
                r.fl   = 5'b10000;
                r.pl   = 8'h02;
            end
            exp_q.push_back(r);
        end
        run_q();
        pay_q = {8'h11, 8'h22, 8'h33};
        set_pad(8'd3);
        add_pkt(8'd3, 1'b0, 8'h00, EOP, 0);
        run_q();

        // Mid-packet reset abandons the packet; parsing resumes from IDLE
        exp_q.push_back(mk(1'b1, SOP));
        exp_q.push_back(mk(1'b1, 8'h03));
        r   = mk(1'b1, 8'h11);
        r.v = 1'b1;
        r.d = 8'h11;
        r.f = 1'b1;
        exp_q.push_back(r);
        run_q();
        do_reset();
        exp_q.push_back(mk(1'b1, 8'h77));
        pay_q = {8'hA5};
        set_pad(8'd1);
        add_pkt(8'd1, 1'b0, 8'h00, EOP, 0);
        run_q();

        // Randomized packets with short gaps, junk between packets, assorted errors
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(7, 0);
            if ($urandom_range(3, 0) == 0) begin
                jb = 8'($urandom);
                if (jb == SOP) jb = 8'h00;
                exp_q.push_back(mk(1'b1, jb));
            end
            if (sel == 0) begin
                len = ($urandom_range(1, 0) == 0) ? 8'd0 : 8'($urandom_range(255, MAX_LEN + 1));
                add_bad_len(len, 3);
            end else begin
                len = 8'($urandom_range(MAX_LEN, 1));
                pay_q.delete();
                for (int i = 0; i < int'(len); i++) begin
                    pay_q.push_back(($urandom_range(7, 0) == 0) ? SOP : 8'($urandom));
                end
                set_pad(len);
                if (padv_q.size() > 0 && $urandom_range(3, 0) == 0) begin
                    padv_q[$urandom_range(padv_q.size() - 1, 0)] = 8'($urandom_range(255, 1));
                end
                eop_b = ($urandom_range(5, 0) == 0) ? 8'($urandom) : EOP;
                add_pkt(len, ($urandom_range(4, 0) == 0), 8'($urandom), eop_b, 3);
            end
            run_q();
        end

        @(posedge clk);
        #1;
        chk("final_good_cnt", 32'(bus.good_cnt), 32'(mdl_good));
        chk("final_bad_cnt",  32'(bus.bad_cnt),  32'(mdl_bad));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
